// File: rtl/gpio_stream_capture_pkg.sv
// Shared constants and types for the GPIO stream capture block: pin count,
// settings-word field offsets and capture mode encodings.
package gpio_stream_capture_pkg;

    localparam int PIN_COUNT     = 32;
    localparam int PIN_SEL_W     = 5;
    localparam int MODE_W        = 2;

    localparam int CFG_I_SEL_LSB = 0;
    localparam int CFG_Q_SEL_LSB = 8;
    localparam int CFG_MODE_LSB  = 16;
    localparam int CFG_REAL_BIT  = 20;

    typedef enum logic [MODE_W-1:0] {
        MODE_DIRECT   = 2'd0,
        MODE_MAJORITY = 2'd1,
        MODE_EDGE     = 2'd2,
        MODE_RSVD     = 2'd3
    } cap_mode_e;

    typedef struct packed {
        logic                 real_en;
        cap_mode_e            mode;
        logic [PIN_SEL_W-1:0] q_sel;
        logic [PIN_SEL_W-1:0] i_sel;
    } chan_cfg_t;

    localparam chan_cfg_t CFG_RESET = '{
        real_en: 1'b0,
        mode:    MODE_DIRECT,
        q_sel:   5'd0,
        i_sel:   5'd0
    };

endpackage

// File: rtl/gpio_stream_capture_chan.sv
// One capture channel (gpio_chan_capture): settings register, I/Q pin muxes and
// per-window direct/majority/edge logic. Edge mode exists only with GPIO_CAPTURE_EDGE_EN.
module gpio_chan_capture
    import gpio_stream_capture_pkg::*;
#(
    parameter int         CNT_W = 8,
    parameter logic [6:0] ADDR  = 7'd64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic                 strobe_i,
    input  logic [6:0]           wr_addr_i,
    input  logic [31:0]          wr_data_i,
    input  logic                 wr_en_i,
    input  logic [PIN_COUNT-1:0] sample_i,
    output logic                 dig_i_o,
    output logic                 dig_q_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    chan_cfg_t        cfg_q, cfg_d, wr_cfg_s;
    logic [CNT_W-1:0] cnt_n_q, cnt_n_d, cnt_ki_q, cnt_ki_d, cnt_kq_q, cnt_kq_d;
    logic [CNT_W-1:0] n_eff_s, ki_eff_s, kq_eff_s;
    logic             out_i_q, out_i_d, out_q_q, out_q_d;
    logic             wr_s, strobe_s, clr_s, sat_s;
    logic             bit_i_s, bit_q_s, maj_i_s, maj_q_s, sel_i_s, sel_q_s;
    logic             unused_s;

    assign wr_s     = wr_en_i && (wr_addr_i == ADDR);
    assign strobe_s = enable_i && strobe_i;
    // A strobe, a settings write or a disabled cycle all start a fresh window.
    assign clr_s    = !enable_i || wr_s || strobe_s;
    assign bit_i_s  = sample_i[cfg_q.i_sel];
    assign bit_q_s  = sample_i[cfg_q.q_sel];
    assign unused_s = ^{wr_data_i[31:21], wr_data_i[19:18], wr_data_i[15:13], wr_data_i[7:5]};

    // Decode an incoming settings word.
    always_comb begin
        wr_cfg_s         = CFG_RESET;
        wr_cfg_s.i_sel   = wr_data_i[CFG_I_SEL_LSB +: PIN_SEL_W];
        wr_cfg_s.q_sel   = wr_data_i[CFG_Q_SEL_LSB +: PIN_SEL_W];
        wr_cfg_s.mode    = cap_mode_e'(wr_data_i[CFG_MODE_LSB +: MODE_W]);
        wr_cfg_s.real_en = wr_data_i[CFG_REAL_BIT];
    end

    // Counts including the current cycle's sample; frozen once N saturates.
    assign sat_s    = (cnt_n_q == CNT_MAX);
    assign n_eff_s  = sat_s ? cnt_n_q  : cnt_n_q + CNT_W'(1);
    assign ki_eff_s = sat_s ? cnt_ki_q : cnt_ki_q + CNT_W'(bit_i_s);
    assign kq_eff_s = sat_s ? cnt_kq_q : cnt_kq_q + CNT_W'(bit_q_s);
    assign maj_i_s  = {ki_eff_s, 1'b0} > {1'b0, n_eff_s};
    assign maj_q_s  = {kq_eff_s, 1'b0} > {1'b0, n_eff_s};

`ifdef GPIO_CAPTURE_EDGE_EN
    logic edge_i_q, edge_i_d, edge_q_q, edge_q_d;
    logic prev_i_q, prev_q_q, prev_vld_q;
    logic edge_i_s, edge_q_s;

    // The first sample after a settings write has no same-pin predecessor.
    assign edge_i_s = edge_i_q || (prev_vld_q && (bit_i_s != prev_i_q));
    assign edge_q_s = edge_q_q || (prev_vld_q && (bit_q_s != prev_q_q));

    // Sticky edge flags restart with the window.
    always_comb begin
        edge_i_d = edge_i_s;
        edge_q_d = edge_q_s;
        if (clr_s) begin
            edge_i_d = 1'b0;
            edge_q_d = 1'b0;
        end else begin
            edge_i_d = edge_i_s;
            edge_q_d = edge_q_s;
        end
    end

    // Edge-detection state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            edge_i_q   <= 1'b0;
            edge_q_q   <= 1'b0;
            prev_i_q   <= 1'b0;
            prev_q_q   <= 1'b0;
            prev_vld_q <= 1'b0;
        end else begin
            edge_i_q   <= edge_i_d;
            edge_q_q   <= edge_q_d;
            prev_i_q   <= bit_i_s;
            prev_q_q   <= bit_q_s;
            prev_vld_q <= !wr_s;
        end
    end
`endif

    // Mode select; reserved (and edge when not built) fall back to direct.
    always_comb begin
        sel_i_s = bit_i_s;
        sel_q_s = bit_q_s;
        case (cfg_q.mode)
            MODE_MAJORITY: begin
                sel_i_s = maj_i_s;
                sel_q_s = maj_q_s;
            end
`ifdef GPIO_CAPTURE_EDGE_EN
            MODE_EDGE: begin
                sel_i_s = edge_i_s;
                sel_q_s = edge_q_s;
            end
`endif
            default: begin
                sel_i_s = bit_i_s;
                sel_q_s = bit_q_s;
            end
        endcase
    end

    // Next state for settings, window counters and captured outputs.
    always_comb begin
        cfg_d    = cfg_q;
        cnt_n_d  = cnt_n_q;
        cnt_ki_d = cnt_ki_q;
        cnt_kq_d = cnt_kq_q;
        out_i_d  = out_i_q;
        out_q_d  = out_q_q;
        if (wr_s) begin
            cfg_d = wr_cfg_s;
        end else begin
            cfg_d = cfg_q;
        end
        if (strobe_s) begin
            out_i_d = sel_i_s;
            out_q_d = cfg_q.real_en ? 1'b0 : sel_q_s;
        end else begin
            out_i_d = out_i_q;
            out_q_d = out_q_q;
        end
        if (clr_s) begin
            cnt_n_d  = '0;
            cnt_ki_d = '0;
            cnt_kq_d = '0;
        end else begin
            cnt_n_d  = n_eff_s;
            cnt_ki_d = ki_eff_s;
            cnt_kq_d = kq_eff_s;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_q    <= CFG_RESET;
            cnt_n_q  <= '0;
            cnt_ki_q <= '0;
            cnt_kq_q <= '0;
            out_i_q  <= 1'b0;
            out_q_q  <= 1'b0;
        end else begin
            cfg_q    <= cfg_d;
            cnt_n_q  <= cnt_n_d;
            cnt_ki_q <= cnt_ki_d;
            cnt_kq_q <= cnt_kq_d;
            out_i_q  <= out_i_d;
            out_q_q  <= out_q_d;
        end
    end

    assign dig_i_o = out_i_q;
    assign dig_q_o = out_q_q;

endmodule

// File: rtl/gpio_stream_capture.sv
// GPIO stream capture top: reset/pad synchronisers, per-channel capture instances
// and the dig_valid pulse. Optional edge mode is enabled by GPIO_CAPTURE_EDGE_EN.
module gpio_stream_capture
    import gpio_stream_capture_pkg::*;
#(
    parameter int         NUM_CHAN = 2,
    parameter int         CNT_W    = 8,
    parameter logic [6:0] SEL_ADDR = 7'd64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                out_strobe,
    input  logic [6:0]          serial_addr,
    input  logic [31:0]         serial_data,
    input  logic                serial_strobe,
    input  logic [15:0]         io_rx_a_in,
    input  logic [15:0]         io_rx_b_in,
    output logic [NUM_CHAN-1:0] dig_i,
    output logic [NUM_CHAN-1:0] dig_q,
    output logic                dig_valid
);

    logic                 rst_meta_q, rst_sync_q;
    logic [PIN_COUNT-1:0] pad_meta_q, pad_sync_q;
    logic                 dig_valid_q, dig_valid_d;

    // Reset asserts asynchronously and releases on the second clock edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    // Two-flop synchroniser for all 32 pads.
    always_ff @(posedge clock or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            pad_meta_q <= '0;
            pad_sync_q <= '0;
        end else begin
            pad_meta_q <= {io_rx_b_in, io_rx_a_in};
            pad_sync_q <= pad_meta_q;
        end
    end

    assign dig_valid_d = enable && out_strobe;

    // Valid pulse aligned with the channels' registered outputs.
    always_ff @(posedge clock or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            dig_valid_q <= 1'b0;
        end else begin
            dig_valid_q <= dig_valid_d;
        end
    end

    assign dig_valid = dig_valid_q;

    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
        gpio_chan_capture #(
            .CNT_W (CNT_W),
            .ADDR  (SEL_ADDR + 7'(c))
        ) u_chan (
            .clk_i     (clock),
            .rst_ni    (rst_sync_q),
            .enable_i  (enable),
            .strobe_i  (out_strobe),
            .wr_addr_i (serial_addr),
            .wr_data_i (serial_data),
            .wr_en_i   (serial_strobe),
            .sample_i  (pad_sync_q),
            .dig_i_o   (dig_i[c]),
            .dig_q_o   (dig_q[c])
        );
    end

endmodule

// File: tb/tb_gpio_stream_capture.sv
// Directed bench for gpio_stream_capture: table of direct-mode vectors plus
// hand sequences for majority, saturation, edge, enable and reset behaviour.
module tb_gpio_stream_capture;

`ifdef GPIO_CAPTURE_EDGE_EN
    localparam bit EDGE_ON = 1'b1;
`else
    localparam bit EDGE_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        out_strobe;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic        serial_strobe;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [1:0]  dig_i, dig_q, dig_i4, dig_q4;
    logic        dig_valid, dig_valid4;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    gpio_stream_capture u_dut (
        .clock(clock), .reset(reset), .enable(enable), .out_strobe(out_strobe),
        .serial_addr(serial_addr), .serial_data(serial_data), .serial_strobe(serial_strobe),
        .io_rx_a_in(a_in), .io_rx_b_in(b_in),
        .dig_i(dig_i), .dig_q(dig_q), .dig_valid(dig_valid)
    );

    gpio_stream_capture #(.CNT_W(4)) u_dut4 (
        .clock(clock), .reset(reset), .enable(enable), .out_strobe(out_strobe),
        .serial_addr(serial_addr), .serial_data(serial_data), .serial_strobe(serial_strobe),
        .io_rx_a_in(a_in), .io_rx_b_in(b_in),
        .dig_i(dig_i4), .dig_q(dig_q4), .dig_valid(dig_valid4)
    );

    typedef struct {
        logic [31:0] cfg0;
        logic [31:0] cfg1;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  exp_i;
        logic [1:0]  exp_q;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [31:0] mk_cfg(input int i, input int q, input int m, input int r);
        return (32'(i) & 32'h1F) | ((32'(q) & 32'h1F) << 8) |
               ((32'(m) & 32'h3) << 16) | ((32'(r) & 32'h1) << 20);
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic stb, input logic wr, input logic [6:0] addr,
                         input logic [31:0] data, input logic [15:0] pa, input logic [15:0] pb);
        enable        = en;
        out_strobe    = stb;
        serial_strobe = wr;
        serial_addr   = addr;
        serial_data   = data;
        a_in          = pa;
        b_in          = pb;
        @(posedge clock);
        #1;
    endtask

    task automatic run_window(input logic [9:0] pat);
        for (int j = 0; j < 10; j++) begin
            drive(1'b1, (j == 9), 1'b0, 7'd0, 32'd0, pat[j] ? 16'h0004 : 16'h0000, 16'h0000);
        end
    endtask

    initial begin
        logic e_w1, e_w4;
        vecs[0] = '{mk_cfg(14, 31, 0, 0), mk_cfg(0, 1, 0, 0),   16'h4001, 16'h0000, 2'b11, 2'b00};
        vecs[1] = '{mk_cfg(31, 16, 0, 0), mk_cfg(15, 17, 0, 0), 16'h8000, 16'h8001, 2'b11, 2'b01};
        vecs[2] = '{mk_cfg(16, 16, 0, 1), mk_cfg(3, 4, 0, 0),   16'h0010, 16'h0001, 2'b01, 2'b10};
        vecs[3] = '{mk_cfg(5, 20, 3, 0),  mk_cfg(20, 5, 3, 0),  16'h0000, 16'h0010, 2'b10, 2'b01};
        vecs[4] = '{mk_cfg(0, 0, 0, 0),   mk_cfg(31, 30, 0, 0), 16'hFFFF, 16'h7FFF, 2'b01, 2'b11};
        vecs[5] = '{mk_cfg(7, 23, 0, 0),  mk_cfg(9, 25, 0, 0),  16'h0000, 16'h0000, 2'b00, 2'b00};
        e_w1 = EDGE_ON ? 1'b1 : 1'b0;
        e_w4 = EDGE_ON ? 1'b0 : 1'b1;

        reset = 1'b0; enable = 1'b0; out_strobe = 1'b0; serial_strobe = 1'b0;
        serial_addr = 7'd0; serial_data = 32'd0; a_in = 16'hFFFF; b_in = 16'hFFFF;
        repeat (3) @(posedge clock);
        #1;
        check("reset_i", {2'b00, dig_i}, 4'h0);
        check("reset_q", {2'b00, dig_q}, 4'h0);
        check("reset_valid", {3'b000, dig_valid}, 4'h0);
        reset = 1'b1;
        repeat (4) drive(1'b1, 1'b0, 1'b0, 7'd0, 32'd0, 16'h0000, 16'h0000);

        for (int v = 0; v < 6; v++) begin
            drive(1'b1, 1'b0, 1'b1, 7'd64, vecs[v].cfg0, vecs[v].a, vecs[v].b);
            drive(1'b1, 1'b0, 1'b1, 7'd65, vecs[v].cfg1, vecs[v].a, vecs[v].b);
            drive(1'b1, 1'b0, 1'b0, 7'd0, 32'd0, vecs[v].a, vecs[v].b);
            drive(1'b1, 1'b0, 1'b0, 7'd0, 32'd0, vecs[v].a, vecs[v].b);
            check($sformatf("v%0d_valid_pre", v), {3'b000, dig_valid}, 4'h0);
            drive(1'b1, 1'b1, 1'b0, 7'd0, 32'd0, vecs[v].a, vecs[v].b);
            check($sformatf("v%0d_i", v), {2'b00, dig_i}, {2'b00, vecs[v].exp_i});
            check($sformatf("v%0d_q", v), {2'b00, dig_q}, {2'b00, vecs[v].exp_q});
            check($sformatf("v%0d_valid", v), {3'b000, dig_valid}, 4'h1);
            drive(1'b1, 1'b0, 1'b0, 7'd0, 32'd0, vecs[v].a, vecs[v].b);
            check($sformatf("v%0d_valid_post", v), {3'b000, dig_valid}, 4'h0);
        end

        // Majority on ch0 pin 2, Q forced low; ch1 stays on pins 9/25 which remain low.
        drive(1'b1, 1'b0, 1'b1, 7'd64, mk_cfg(2, 2, 1, 1), 16'h0000, 16'h0000);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 7'd0, 32'd0, 16'h0000, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 7'd0, 32'd0, 16'h0000, 16'h0000);
        check("maj_sync_i", {2'b00, dig_i}, 4'h0);
        run_window(10'b00_1111_1100);
        check("maj_6of10_i", {2'b00, dig_i}, 4'h1);
        check("maj_6of10_valid", {3'b000, dig_valid}, 4'h1);
        run_window(10'b00_0111_1100);
        check("maj_5of10_i", {2'b00, dig_i}, 4'h0);
        check("maj_5of10_q", {2'b00, dig_q}, 4'h0);

        // Saturation: 40-sample window, first 20 samples high.
        drive(1'b1, 1'b0, 1'b0, 7'd0, 32'd0, 16'h0004, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 7'd0, 32'd0, 16'h0004, 16'h0000);
        for (int j = 1; j <= 40; j++) begin
            drive(1'b1, (j == 40), 1'b0, 7'd0, 32'd0, (j <= 18) ? 16'h0004 : 16'h0000, 16'h0000);
        end
        check("sat_cnt4_i", {2'b00, dig_i4}, 4'h1);
        check("sat_cnt4_valid", {3'b000, dig_valid4}, 4'h1);
        check("sat_cnt4_q", {2'b00, dig_q4}, 4'h0);
        check("nosat_cnt8_i", {2'b00, dig_i}, 4'h0);

        // Edge mode on ch0 pin 2.
        drive(1'b1, 1'b0, 1'b1, 7'd64, mk_cfg(2, 2, 2, 1), 16'h0000, 16'h0000);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 7'd0, 32'd0, 16'h0000, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 7'd0, 32'd0, 16'h0000, 16'h0000);
        run_window(10'b00_0000_1000);
        check("edge_pulse_i", {2'b00, dig_i}, {3'b000, e_w1});
        run_window(10'b00_0000_0000);
        check("edge_quiet_i", {2'b00, dig_i}, 4'h0);
        run_window(10'b11_1111_1111);
        check("edge_rise_i", {2'b00, dig_i}, 4'h1);
        run_window(10'b11_1111_1111);
        check("edge_high_i", {2'b00, dig_i}, {3'b000, e_w4});

        // Disabled: strobes ignored, outputs held.
        for (int j = 0; j < 5; j++) begin
            drive(1'b0, 1'b1, 1'b0, 7'd0, 32'd0, 16'hFFFF, 16'hFFFF);
            check($sformatf("dis%0d_valid", j), {3'b000, dig_valid}, 4'h0);
            check($sformatf("dis%0d_i", j), {2'b00, dig_i}, {3'b000, e_w4});
        end

        // Asynchronous reset in the cycle after a strobe.
        drive(1'b1, 1'b0, 1'b1, 7'd64, mk_cfg(2, 2, 0, 0), 16'h0004, 16'h0000);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 7'd0, 32'd0, 16'h0004, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 7'd0, 32'd0, 16'h0004, 16'h0000);
        check("prerst_i", {2'b00, dig_i}, 4'h1);
        check("prerst_q", {2'b00, dig_q}, 4'h1);
        check("prerst_valid", {3'b000, dig_valid}, 4'h1);
        out_strobe = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_i", {2'b00, dig_i}, 4'h0);
        check("rst_async_q", {2'b00, dig_q}, 4'h0);
        check("rst_async_valid", {3'b000, dig_valid}, 4'h0);
        repeat (2) drive(1'b1, 1'b0, 1'b0, 7'd0, 32'd0, 16'h0001, 16'h0000);
        reset = 1'b1;
        repeat (6) drive(1'b1, 1'b0, 1'b0, 7'd0, 32'd0, 16'h0001, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 7'd0, 32'd0, 16'h0001, 16'h0000);
        check("postrst_i", {2'b00, dig_i}, 4'h3);
        check("postrst_q", {2'b00, dig_q}, 4'h3);
        check("postrst_valid", {3'b000, dig_valid}, 4'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
